// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The slave side is the sequencer; the master side is the datapath that feeds it.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_r1_num;
   logic [4:0]       id_r2_num;
   logic             id_r1_used;
   logic             id_r2_used;
   logic             ex_memtoreg;
   logic             ex_regwrite;
   logic [4:0]       ex_w_num;
   logic             ex_redirect;
   logic             ex_halt_req;
   logic             go;
   logic             pc_hold;
   logic             ifid_hold;
   logic             ifid_flush;
   logic             idex_hold;
   logic             idex_flush;
   logic             halted;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_r1_num, id_r2_num, id_r1_used, id_r2_used,
      output ex_memtoreg, ex_regwrite, ex_w_num, ex_redirect, ex_halt_req, go,
      input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, halted,
      input  cycle_count, stall_count, flush_count
   );

   modport slave (
      input  id_r1_num, id_r2_num, id_r1_used, id_r2_used,
      input  ex_memtoreg, ex_regwrite, ex_w_num, ex_redirect, ex_halt_req, go,
      output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, halted,
      output cycle_count, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, EX redirects and the
// SYSCALL halt/resume sequence, plus saturating cycle/stall/flush counters.

module pipeline_hazard_ctrl_chk (
   input logic clk,
   input logic ifid_hold,
   input logic ifid_flush,
   input logic idex_hold,
   input logic idex_flush
);
   // Hold wins over flush in the pipeline registers, so both at once would silently drop a flush.
   a_ifid_excl: assert property (@(posedge clk) !(ifid_hold && ifid_flush));
   a_idex_excl: assert property (@(posedge clk) !(idex_hold && idex_flush));
endmodule

module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALT   = 2'd1,
      ST_RESUME = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic             load_use_s;
   logic             pc_hold_s;
   logic             ifid_hold_s;
   logic             ifid_flush_s;
   logic             idex_hold_s;
   logic             idex_flush_s;
   logic             halted_s;
   logic             cycle_ev_s;
   logic             stall_ev_s;
   logic             flush_ev_s;
   logic [CNT_W-1:0] cycle_count_r;
   logic [CNT_W-1:0] stall_count_r;
   logic [CNT_W-1:0] flush_count_r;

   assign load_use_s = bus.ex_memtoreg & bus.ex_regwrite & (bus.ex_w_num != 5'd0) &
                       ((bus.id_r1_used & (bus.id_r1_num == bus.ex_w_num)) |
                        (bus.id_r2_used & (bus.id_r2_num == bus.ex_w_num)));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, same-cycle hold/flush controls and counter events.
   always_comb begin
      state_nxt_s  = state_r;
      pc_hold_s    = 1'b0;
      ifid_hold_s  = 1'b0;
      ifid_flush_s = 1'b0;
      idex_hold_s  = 1'b0;
      idex_flush_s = 1'b0;
      halted_s     = 1'b0;
      cycle_ev_s   = 1'b0;
      stall_ev_s   = 1'b0;
      flush_ev_s   = 1'b0;
      if (rst) begin
         ifid_flush_s = 1'b1;
         idex_flush_s = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               cycle_ev_s = 1'b1;
               // A halting SYSCALL freezes everything, even a redirect behind it.
               if (bus.ex_halt_req) begin
                  pc_hold_s   = 1'b1;
                  ifid_hold_s = 1'b1;
                  idex_hold_s = 1'b1;
                  state_nxt_s = ST_HALT;
               end else if (bus.ex_redirect) begin
                  ifid_flush_s = 1'b1;
                  idex_flush_s = 1'b1;
                  flush_ev_s   = 1'b1;
               end else if (load_use_s) begin
                  pc_hold_s    = 1'b1;
                  ifid_hold_s  = 1'b1;
                  idex_flush_s = 1'b1;
                  stall_ev_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_HALT: begin
               pc_hold_s   = 1'b1;
               ifid_hold_s = 1'b1;
               idex_hold_s = 1'b1;
               halted_s    = 1'b1;
               if (bus.go) begin
                  state_nxt_s = ST_RESUME;
               end else begin
                  state_nxt_s = ST_HALT;
               end
            end
            ST_RESUME: begin
               // Squash the SYSCALL still sitting in ID/EX.
               idex_flush_s = 1'b1;
               cycle_ev_s   = 1'b1;
               state_nxt_s  = ST_RUN;
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count_r <= '0;
         stall_count_r <= '0;
         flush_count_r <= '0;
      end else begin
         if (cycle_ev_s && (cycle_count_r != CNT_MAX)) cycle_count_r <= cycle_count_r + CNT_ONE;
         if (stall_ev_s && (stall_count_r != CNT_MAX)) stall_count_r <= stall_count_r + CNT_ONE;
         if (flush_ev_s && (flush_count_r != CNT_MAX)) flush_count_r <= flush_count_r + CNT_ONE;
      end
   end

   assign bus.pc_hold     = pc_hold_s;
   assign bus.ifid_hold   = ifid_hold_s;
   assign bus.ifid_flush  = ifid_flush_s;
   assign bus.idex_hold   = idex_hold_s;
   assign bus.idex_flush  = idex_flush_s;
   assign bus.halted      = halted_s;
   assign bus.cycle_count = cycle_count_r;
   assign bus.stall_count = stall_count_r;
   assign bus.flush_count = flush_count_r;

   pipeline_hazard_ctrl_chk u_chk (
      .clk        (clk),
      .ifid_hold  (ifid_hold_s),
      .ifid_flush (ifid_flush_s),
      .idex_hold  (idex_hold_s),
      .idex_flush (idex_flush_s)
   );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run against a
// mode/event-count reference model; a 4-bit-counter instance shadows the 32-bit one.
module tb_pipeline_hazard_ctrl;
   localparam int M_RUN = 0, M_HALT = 1, M_RESUME = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(32)) bus();
   pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4();

   assign bus4.id_r1_num   = bus.id_r1_num;
   assign bus4.id_r2_num   = bus.id_r2_num;
   assign bus4.id_r1_used  = bus.id_r1_used;
   assign bus4.id_r2_used  = bus.id_r2_used;
   assign bus4.ex_memtoreg = bus.ex_memtoreg;
   assign bus4.ex_regwrite = bus.ex_regwrite;
   assign bus4.ex_w_num    = bus.ex_w_num;
   assign bus4.ex_redirect = bus.ex_redirect;
   assign bus4.ex_halt_req = bus.ex_halt_req;
   assign bus4.go          = bus.go;

   pipeline_hazard_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   pipeline_hazard_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

   // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, halted}
   logic [5:0] ctl, ctl4;
   assign ctl  = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_hold, bus.idex_flush, bus.halted};
   assign ctl4 = {bus4.pc_hold, bus4.ifid_hold, bus4.ifid_flush, bus4.idex_hold, bus4.idex_flush, bus4.halted};

   int     tests = 0;
   int     fails = 0;
   int     mode_m = M_RUN;
   longint cyc_m = 0, stl_m = 0, fl_m = 0;

   function automatic logic [31:0] sat32(longint v);
      return (v > 64'sd4294967295) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   function automatic logic [3:0] sat4(longint v);
      return (v > 64'sd15) ? 4'hF : v[3:0];
   endfunction

   // ID needs a register that a non-zero-destination load in EX has not yet produced.
   function automatic bit model_lu();
      bit needs_load = bus.ex_memtoreg && bus.ex_regwrite && (bus.ex_w_num != 5'd0);
      bit r1_hit = bus.id_r1_used && (bus.id_r1_num == bus.ex_w_num);
      bit r2_hit = bus.id_r2_used && (bus.id_r2_num == bus.ex_w_num);
      return needs_load && (r1_hit || r2_hit);
   endfunction

   function automatic logic [5:0] exp_ctrl();
      if (rst) return 6'b001010;
      if (mode_m == M_HALT) return 6'b110101;
      if (mode_m == M_RESUME) return 6'b000010;
      if (bus.ex_halt_req) return 6'b110100;
      if (bus.ex_redirect) return 6'b001010;
      if (model_lu()) return 6'b110010;
      return 6'b000000;
   endfunction

   task automatic model_clock();
      if (rst) begin
         mode_m = M_RUN; cyc_m = 0; stl_m = 0; fl_m = 0;
      end else if (mode_m == M_RUN) begin
         cyc_m++;
         if (bus.ex_halt_req) mode_m = M_HALT;
         else if (bus.ex_redirect) fl_m++;
         else if (model_lu()) stl_m++;
      end else if (mode_m == M_HALT) begin
         if (bus.go) mode_m = M_RESUME;
      end else begin
         cyc_m++;
         mode_m = M_RUN;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        input logic mem, input logic rw, input logic [4:0] w,
                        input logic redir, input logic halt, input logic g);
      bus.id_r1_num = r1;  bus.id_r1_used = u1;
      bus.id_r2_num = r2;  bus.id_r2_used = u2;
      bus.ex_memtoreg = mem; bus.ex_regwrite = rw; bus.ex_w_num = w;
      bus.ex_redirect = redir; bus.ex_halt_req = halt; bus.go = g;
   endtask

   task automatic idle();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; idle(); tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      tests++; if (ctl !== 6'b001010) begin fails++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b001010); end
      tests++; if (ctl4 !== 6'b001010) begin fails++; $display("FAIL reset_ctl4: got %b expected %b", ctl4, 6'b001010); end
      tick(); rst = 1'b0; idle();
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL reset_run_ctl: got %b expected %b", ctl, 6'b000000); end
      tests++;
      if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== 96'd0) begin
         fails++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", bus.cycle_count, bus.stall_count, bus.flush_count);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b110010) begin fails++; $display("FAIL load_use_stall: got %b expected %b", ctl, 6'b110010); end
      tick();
      drive(5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL load_use_release: got %b expected %b", ctl, 6'b000000); end
      tests++; if (bus.stall_count !== 32'd1) begin fails++; $display("FAIL load_use_count: got %0d expected 1", bus.stall_count); end
      tick();
   endtask

   task automatic test_zero_no_use();
      do_reset();
      drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL zero_reg: got %b expected %b", ctl, 6'b000000); end
      tick();
      drive(5'd3, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL unused_r2: got %b expected %b", ctl, 6'b000000); end
      tick(); idle();
      @(negedge clk);
      tests++; if (bus.stall_count !== 32'd0) begin fails++; $display("FAIL no_stall_count: got %0d expected 0", bus.stall_count); end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b001010) begin fails++; $display("FAIL redirect_ctl: got %b expected %b", ctl, 6'b001010); end
      tick(); idle();
      @(negedge clk);
      tests++; if (bus.flush_count !== 32'd1) begin fails++; $display("FAIL redirect_flush_count: got %0d expected 1", bus.flush_count); end
      tests++; if (bus.stall_count !== 32'd0) begin fails++; $display("FAIL redirect_stall_count: got %0d expected 0", bus.stall_count); end
      tick();
   endtask

   task automatic test_halt_resume();
      do_reset();
      drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      tests++; if (ctl !== 6'b110100) begin fails++; $display("FAIL halt_entry: got %b expected %b", ctl, 6'b110100); end
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(5'($urandom_range(0, 3)), 1'b1, 5'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)),
               1'b1, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         @(negedge clk);
         tests++; if (ctl !== 6'b110101) begin fails++; $display("FAIL halt_hold[%0d]: got %b expected %b", i, ctl, 6'b110101); end
         tests++; if (bus.cycle_count !== 32'd1) begin fails++; $display("FAIL halt_frozen[%0d]: got %0d expected 1", i, bus.cycle_count); end
         tick();
      end
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      tests++; if (ctl !== 6'b110101) begin fails++; $display("FAIL halt_go_cycle: got %b expected %b", ctl, 6'b110101); end
      tick();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      tests++; if (ctl !== 6'b000010) begin fails++; $display("FAIL resume_ctl: got %b expected %b", ctl, 6'b000010); end
      tick(); idle();
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL resume_to_run: got %b expected %b", ctl, 6'b000000); end
      tests++; if (bus.cycle_count !== 32'd2) begin fails++; $display("FAIL resume_cycle_count: got %0d expected 2", bus.cycle_count); end
      tick();
   endtask

   task automatic test_reset_in_halt();
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      @(negedge clk);
      tests++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL rst_halt_pre: got %b expected 1", bus.halted); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (ctl !== 6'b001010) begin fails++; $display("FAIL rst_in_halt_ctl: got %b expected %b", ctl, 6'b001010); end
      tick(); rst = 1'b0; idle();
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL rst_in_halt_run: got %b expected %b", ctl, 6'b000000); end
      tests++; if (bus.cycle_count !== 32'd0) begin fails++; $display("FAIL rst_in_halt_cnt: got %0d expected 0", bus.cycle_count); end
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      bus.go = 1'b1;
      tick();
      rst = 1'b1; idle();
      @(negedge clk);
      tests++; if (ctl !== 6'b001010) begin fails++; $display("FAIL rst_in_resume_ctl: got %b expected %b", ctl, 6'b001010); end
      tick(); rst = 1'b0;
      @(negedge clk);
      tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL rst_in_resume_run: got %b expected %b", ctl, 6'b000000); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests++;
         if (bus4.cycle_count !== sat4(longint'(i))) begin
            fails++; $display("FAIL sat_cycle4[%0d]: got %0d expected %0d", i, bus4.cycle_count, sat4(longint'(i)));
         end
         tick();
      end
      @(negedge clk);
      tests++; if (bus4.cycle_count !== 4'd15) begin fails++; $display("FAIL sat_final4: got %0d expected 15", bus4.cycle_count); end
      tests++; if (bus.cycle_count !== 32'd20) begin fails++; $display("FAIL sat_final32: got %0d expected 20", bus.cycle_count); end
      tick();
   endtask

   task automatic test_random();
      logic [5:0] e;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 3) == 0));
         @(negedge clk);
         e = exp_ctrl();
         tests++; if (ctl !== e) begin fails++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, ctl, e); end
         tests++; if (ctl4 !== e) begin fails++; $display("FAIL rand_ctl4[%0d]: got %b expected %b", i, ctl4, e); end
         tests++;
         if ({bus.cycle_count, bus.stall_count, bus.flush_count} !== {sat32(cyc_m), sat32(stl_m), sat32(fl_m)}) begin
            fails++; $display("FAIL rand_cnt32[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, bus.cycle_count,
                              bus.stall_count, bus.flush_count, sat32(cyc_m), sat32(stl_m), sat32(fl_m));
         end
         tests++;
         if ({bus4.cycle_count, bus4.stall_count, bus4.flush_count} !== {sat4(cyc_m), sat4(stl_m), sat4(fl_m)}) begin
            fails++; $display("FAIL rand_cnt4[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, bus4.cycle_count,
                              bus4.stall_count, bus4.flush_count, sat4(cyc_m), sat4(stl_m), sat4(fl_m));
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_zero_no_use();
      test_redirect();
      test_halt_resume();
      test_reset_in_halt();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the IF/ID and ID/EX pipeline registers and the PC register, and drives their hold (en) and flush (rst) inputs. It covers three cases: load-use hazards, taken-branch/jump redirects resolved in EX, and the SYSCALL halt/resume sequence. It also keeps cycle, stall and flush performance counters for the board display.

Parameters:
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
id_r1_num  input  5  source register 1 of the instruction in ID.
id_r2_num  input  5  source register 2 of the instruction in ID.
id_r1_used  input  1  ID instruction reads r1.
id_r2_used  input  1  ID instruction reads r2.
ex_memtoreg  input  1  instruction in EX is a load (MemToReg).
ex_regwrite  input  1  instruction in EX writes a register.
ex_w_num  input  5  destination register of the instruction in EX.
ex_redirect  input  1  EX resolved a taken BEQ/BNE/BGEZ or a JMP/JAL/JR.
ex_halt_req  input  1  EX holds a SYSCALL whose service is halt.
go  input  1  resume pulse from the board button, already synchronised and single-cycle.
pc_hold  output  1  freeze PC.
ifid_hold  output  1  freeze IF/ID (drives en).
ifid_flush  output  1  clear IF/ID (drives rst).
idex_hold  output  1  freeze ID/EX.
idex_flush  output  1  clear ID/EX.
halted  output  1  FSM is in HALT.
cycle_count  output  CNT_W  cycles spent outside HALT.
stall_count  output  CNT_W  load-use stall cycles.
flush_count  output  CNT_W  redirect flush cycles.

Behaviour:
- Pipeline registers give hold priority over flush. This block therefore never asserts hold and flush on the same register in the same cycle; assertions check this.
- FSM states: RUN, HALT, RESUME. The state is registered. The hold/flush outputs are combinational from the state and the current inputs.
- While rst=1:
  - Outputs: ifid_flush=1, idex_flush=1, all holds=0, halted=0.
  - On the next edge: state<=RUN and all counters<=0.
- RUN, hazard terms:
  - load_use = ex_memtoreg & ex_regwrite & (ex_w_num!=0) & ((id_r1_used & id_r1_num==ex_w_num) | (id_r2_used & id_r2_num==ex_w_num)).
- RUN, priority 1 (highest): ex_halt_req=1.
  - pc_hold=1, ifid_hold=1, idex_hold=1, all flush=0.
  - Next state HALT.
  - This overrides a redirect or load-use in the same cycle.
- RUN, priority 2: ex_redirect=1.
  - ifid_flush=1, idex_flush=1, holds=0.
  - PC loads the target. flush_count+1.
  - A simultaneous load_use is ignored, because the ID instruction is squashed.
- RUN, priority 3: load_use=1.
  - pc_hold=1, ifid_hold=1, idex_flush=1 (bubble), idex_hold=0.
  - stall_count+1.
  - Exactly one stall cycle per load-use; the bubble removes the condition on the next cycle.
- RUN, otherwise: all outputs 0.
- HALT:
  - pc_hold=ifid_hold=idex_hold=1, flushes 0, halted=1.
  - cycle_count frozen.
  - ex_halt_req stays high because the SYSCALL remains in EX; it is ignored in this state.
  - go=1 moves to RESUME.
- RESUME (exactly 1 cycle):
  - idex_flush=1 removes the SYSCALL. pc_hold=0, ifid_hold=0, idex_hold=0, halted=0.
  - Next state RUN unconditionally.
  - go is ignored in this state.
- go in RUN: no effect.
- Counters:
  - cycle_count increments in RUN and RESUME.
  - All counters saturate at 2^CNT_W-1 and do not wrap.
  - Counters update on the same edge as the event.
- rst asserted mid-HALT or mid-RESUME: state returns to RUN on the next edge.
- Latency: hazard response is same-cycle (combinational). The state change takes effect one clock later.

Test Plan:
- Load-use: `lw $8` in EX (ex_w_num=8, memtoreg=1), ID add reads r1=8 -> pc_hold=ifid_hold=idex_flush=1 for exactly 1 cycle; stall_count 0->1; next cycle all 0.
- $zero and no-use: load to ex_w_num=0 with id_r1_num=0, and a separate case with id_r2_num=8 but id_r2_used=0 -> no stall, stall_count unchanged.
- Redirect with a coincident load-use condition: ex_redirect=1, load_use inputs also true -> ifid_flush=idex_flush=1, holds 0; flush_count+1, stall_count unchanged.
- Halt/resume: ex_halt_req=1 in RUN -> all holds=1 that cycle, halted=1 next cycle. Hold 10 cycles: cycle_count constant. Pulse go -> one RESUME cycle with idex_flush=1 and halted=0, then RUN.
- Reset in HALT: rst=1 while halted -> during rst ifid_flush=idex_flush=1 and holds 0; after the edge state RUN and counters 0.
- Saturation: with CNT_W=4, run 20 cycles -> cycle_count stops at 15; hold/flush exclusivity assertion never fires.
